// File: rtl/lsu_pkg.sv
// Shared funct3 encodings and FSM state type for the load/store unit.
// No logic: types and constants only.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store byte enables/replication, load extract/extension, legality check.
// Purely combinational, zero latency; no flow control of its own.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic        is_store,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] bus_rdata,
  output logic [3:0]  be,
  output logic [31:0] lane_wdata,
  output logic [31:0] ext_rdata,
  output logic        illegal
);

  logic [31:0] shifted;

  assign shifted = bus_rdata >> {addr_lo, 3'b000};

  always_comb begin
    be         = 4'b0000;
    lane_wdata = wdata;
    ext_rdata  = 32'h0000_0000;
    illegal    = 1'b0;

    case (funct3)
      F3_B, F3_BU: begin
        be         = 4'b0001 << addr_lo;
        lane_wdata = {4{wdata[7:0]}};
      end
      F3_H, F3_HU: begin
        be         = 4'b0011 << {addr_lo[1], 1'b0};
        lane_wdata = {2{wdata[15:0]}};
        illegal    = addr_lo[0];
      end
      F3_W: begin
        be         = 4'b1111;
        illegal    = (addr_lo != 2'b00);
      end
      default: illegal = 1'b1;
    endcase

    // Unsigned variants exist only for loads.
    if (is_store && (funct3 == F3_BU || funct3 == F3_HU))
      illegal = 1'b1;

    case (funct3)
      F3_B:    ext_rdata = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    ext_rdata = {{16{shifted[15]}}, shifted[15:0]};
      F3_W:    ext_rdata = bus_rdata;
      F3_BU:   ext_rdata = {24'h00_0000, shifted[7:0]};
      F3_HU:   ext_rdata = {16'h0000, shifted[15:0]};
      default: ext_rdata = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Core data-port to handshaked bus bridge; store 3 cycles, load 4 cycles minimum.
// Stalls the core until bus_gnt (and bus_rvalid for loads); each bus wait cycle adds one cycle.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              mem_en,
  input  logic              mem_we,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              stall,
  output logic              access_err,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [31:0]       bus_wdata,
  output logic [3:0]        bus_be,
  input  logic              bus_gnt,
  input  logic              bus_rvalid,
  input  logic [31:0]       bus_rdata
);

  lsu_state_t  state;
  logic [2:0]  f3_q;
  logic        we_q;
  logic [1:0]  addr_lo_q;

  logic        idle;
  logic        accept;
  logic [2:0]  al_f3;
  logic        al_store;
  logic [1:0]  al_lo;
  logic [3:0]  al_be;
  logic [31:0] al_wdata;
  logic [31:0] al_rdata;
  logic        al_illegal;

  // One aligner serves both phases: live core inputs in IDLE, latched ones afterwards.
  assign idle     = (state == IDLE);
  assign al_f3    = idle ? funct3     : f3_q;
  assign al_store = idle ? mem_we     : we_q;
  assign al_lo    = idle ? addr[1:0]  : addr_lo_q;

  lsu_align u_align (
    .funct3     (al_f3),
    .is_store   (al_store),
    .addr_lo    (al_lo),
    .wdata      (wdata),
    .bus_rdata  (bus_rdata),
    .be         (al_be),
    .lane_wdata (al_wdata),
    .ext_rdata  (al_rdata),
    .illegal    (al_illegal)
  );

  assign access_err = idle && mem_en && al_illegal;
  assign accept     = idle && mem_en && !al_illegal;
  assign stall      = accept || (state == REQ) || (state == WAIT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      f3_q      <= 3'b000;
      we_q      <= 1'b0;
      addr_lo_q <= 2'b00;
      rdata     <= 32'h0000_0000;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= 32'h0000_0000;
      bus_be    <= 4'b0000;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state     <= REQ;
            f3_q      <= funct3;
            we_q      <= mem_we;
            addr_lo_q <= addr[1:0];
            bus_req   <= 1'b1;
            bus_we    <= mem_we;
            bus_addr  <= {addr[ADDR_W-1:2], 2'b00};
            bus_wdata <= al_wdata;
            bus_be    <= al_be;
          end
        end
        REQ: begin
          if (bus_gnt) begin
            bus_req <= 1'b0;
            state   <= we_q ? DONE : WAIT;
          end
        end
        WAIT: begin
          if (bus_rvalid) begin
            rdata <= al_rdata;
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench with a transaction-level model of the load/store unit.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        mem_en, mem_we;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata, rdata;
  logic        stall, access_err;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_gnt, bus_rvalid;
  logic [31:0] bus_rdata;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_W(32)) dut (
    .clk(clk), .reset_n(reset_n), .mem_en(mem_en), .mem_we(mem_we),
    .funct3(funct3), .addr(addr), .wdata(wdata), .rdata(rdata),
    .stall(stall), .access_err(access_err), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_be(bus_be),
    .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );

  int total = 0;
  int bad = 0;
  int n_gnt = 0;
  int exp_gnt = 0;
  int n_stall = 0;
  bit chk_on = 0;

  logic        exp_stall, exp_err, exp_req, exp_we;
  logic [31:0] exp_addr, exp_wdata, exp_rdata, model_rdata;
  logic [3:0]  exp_be;
  logic [31:0] seen_addr, seen_wdata;
  logic [3:0]  seen_be;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- model ----------------
  function automatic int m_size(input logic [2:0] f3);
    case (f3)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      default:    return 4;
    endcase
  endfunction

  function automatic bit m_legal(input bit we, input logic [2:0] f3, input logic [31:0] a);
    if (f3 == 3'd3 || f3 >= 3'd6) return 0;
    if (we && f3 >= 3'd4) return 0;
    return (int'(a[1:0]) % m_size(f3)) == 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
    int sz = m_size(f3);
    return 4'(((1 << sz) - 1) << a[1:0]);
  endfunction

  function automatic logic [31:0] m_lane(input logic [2:0] f3, input logic [31:0] wd);
    case (m_size(f3))
      1:       return 32'(wd[7:0]) * 32'h0101_0101;
      2:       return 32'(wd[15:0]) * 32'h0001_0001;
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] rw);
    int sz = m_size(f3);
    logic [31:0] v, mask;
    if (sz == 4) return rw;
    v = rw >> (8 * int'(a[1:0]));
    mask = (32'd1 << (8 * sz)) - 32'd1;
    v = v & mask;
    if (f3 < 3'd4 && v[8*sz-1]) v = v | ~mask;
    return v;
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (chk_on) begin
      check("stall", 32'(stall), 32'(exp_stall));
      check("access_err", 32'(access_err), 32'(exp_err));
      check("bus_req", 32'(bus_req), 32'(exp_req));
      check("rdata", rdata, exp_rdata);
      if (stall === 1'b1) n_stall++;
      if (exp_req) begin
        check("bus_addr", bus_addr, exp_addr);
        check("bus_be", 32'(bus_be), 32'(exp_be));
        check("bus_wdata", bus_wdata, exp_wdata);
        check("bus_we", 32'(bus_we), 32'(exp_we));
        seen_addr  = bus_addr;
        seen_be    = bus_be;
        seen_wdata = bus_wdata;
      end
    end
  end

  always @(posedge clk) if (reset_n && bus_req && bus_gnt) n_gnt++;

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    mem_en = 0; bus_gnt = 0; bus_rvalid = 0;
    exp_stall = 0; exp_err = 0; exp_req = 0; exp_rdata = model_rdata;
    tick();
  endtask

  task automatic set_req_exp(input bit we, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] wd);
    exp_req = 1; exp_stall = 1; exp_err = 0; exp_we = we;
    exp_addr = {a[31:2], 2'b00}; exp_be = m_be(f3, a); exp_wdata = m_lane(f3, wd);
  endtask

  task automatic access(input bit we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input int gnt_dly, input int rv_dly,
                        input logic [31:0] rword);
    bit legal = m_legal(we, f3, a);
    mem_en = 1; mem_we = we; funct3 = f3; addr = a; wdata = wd;
    bus_gnt = 0; bus_rvalid = 0;
    exp_stall = legal; exp_err = !legal; exp_req = 0; exp_rdata = model_rdata;
    tick();
    if (!legal) return;
    exp_gnt++;
    for (int i = 0; i <= gnt_dly; i++) begin
      set_req_exp(we, f3, a, wd);
      bus_gnt = (i == gnt_dly);
      // rvalid coinciding with the grant must be ignored
      bus_rvalid = (i == gnt_dly) && !we;
      bus_rdata = ~rword;
      tick();
    end
    bus_gnt = 0;
    exp_req = 0;
    if (!we) begin
      for (int i = 0; i <= rv_dly; i++) begin
        exp_stall = 1;
        bus_rvalid = (i == rv_dly);
        bus_rdata = (i == rv_dly) ? rword : 32'h5A5A_5A5A;
        tick();
      end
      model_rdata = m_load(f3, a, rword);
    end
    bus_rvalid = 0;
    exp_stall = 0; exp_err = 0; exp_rdata = model_rdata;
    tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    mem_en = 0; mem_we = 0; funct3 = 3'b000; addr = 32'h0; wdata = 32'h0;
    bus_gnt = 0; bus_rvalid = 0; bus_rdata = 32'h0;
    exp_stall = 0; exp_err = 0; exp_req = 0; exp_we = 0;
    exp_addr = 0; exp_wdata = 0; exp_be = 0; exp_rdata = 0; model_rdata = 0;
    seen_addr = 0; seen_wdata = 0; seen_be = 0;
    chk_on = 1;

    #12;
    check("rst_rdata", rdata, 32'h0);
    check("rst_bus_req", 32'(bus_req), 32'h0);
    check("rst_bus_we", 32'(bus_we), 32'h0);
    check("rst_bus_addr", bus_addr, 32'h0);
    check("rst_bus_wdata", bus_wdata, 32'h0);
    check("rst_bus_be", 32'(bus_be), 32'h0);
    tick();
    reset_n = 1;
    idle_cycle();
    idle_cycle();

    // SW, no wait states
    n_stall = 0;
    access(1, 3'b010, 32'h100, 32'hDEAD_BEEF, 0, 0, 32'h0);
    check("sw_stall_cycles", 32'(n_stall), 32'd2);
    check("sw_bus_addr", seen_addr, 32'h100);
    check("sw_bus_be", 32'(seen_be), 32'hF);
    check("sw_bus_wdata", seen_wdata, 32'hDEAD_BEEF);
    idle_cycle();

    // SB upper lane
    access(1, 3'b000, 32'h103, 32'h0000_00A5, 1, 0, 32'h0);
    check("sb_bus_be", 32'(seen_be), 32'b1000);
    check("sb_bus_wdata", seen_wdata, 32'hA5A5_A5A5);
    check("sb_bus_addr", seen_addr, 32'h100);
    idle_cycle();

    // LB / LBU with wait states
    access(0, 3'b000, 32'h202, 32'h0, 2, 2, 32'h0080_0000);
    check("lb_rdata", rdata, 32'hFFFF_FF80);
    idle_cycle();
    access(0, 3'b100, 32'h202, 32'h0, 2, 2, 32'h0080_0000);
    check("lbu_rdata", rdata, 32'h0000_0080);
    idle_cycle();

    // illegal accesses: no bus activity, rdata untouched
    access(0, 3'b010, 32'h101, 32'h0, 0, 0, 32'h0);
    access(1, 3'b001, 32'h003, 32'h1234, 0, 0, 32'h0);
    access(0, 3'b011, 32'h200, 32'h0, 0, 0, 32'h0);
    access(1, 3'b100, 32'h200, 32'h0, 0, 0, 32'h0);
    idle_cycle();
    check("err_rdata_kept", rdata, 32'h0000_0080);

    // SH / LW / LHU variants with assorted latencies
    access(1, 3'b001, 32'h402, 32'hCAFE_1357, 0, 0, 32'h0);
    check("sh_bus_be", 32'(seen_be), 32'b1100);
    check("sh_bus_wdata", seen_wdata, 32'h1357_1357);
    access(0, 3'b010, 32'h404, 32'h0, 1, 0, 32'h8765_4321);
    check("lw_rdata", rdata, 32'h8765_4321);
    access(0, 3'b001, 32'h406, 32'h0, 0, 1, 32'hF00D_0000);
    check("lh_rdata", rdata, 32'hFFFF_F00D);
    idle_cycle();

    // reset during WAIT
    mem_en = 1; mem_we = 0; funct3 = 3'b000; addr = 32'h202; wdata = 32'h0;
    exp_stall = 1; exp_err = 0; exp_req = 0; exp_rdata = model_rdata;
    tick();
    set_req_exp(0, 3'b000, 32'h202, 32'h0);
    bus_gnt = 1;
    exp_gnt++;
    tick();
    bus_gnt = 0;
    reset_n = 0; mem_en = 0;
    model_rdata = 32'h0;
    exp_req = 0; exp_stall = 0; exp_rdata = 32'h0;
    tick();
    reset_n = 1;
    bus_rvalid = 1; bus_rdata = 32'hFFFF_FFFF;
    tick();
    bus_rvalid = 0;
    idle_cycle();
    check("rst_mid_rdata", rdata, 32'h0);
    check("rst_mid_bus_req", 32'(bus_req), 32'h0);

    // back-to-back loads
    access(0, 3'b101, 32'h302, 32'h0, 0, 0, 32'h8001_7FFF);
    check("lhu_rdata", rdata, 32'h0000_8001);
    access(0, 3'b001, 32'h300, 32'h0, 0, 0, 32'h8001_7FFF);
    check("lh_b2b_rdata", rdata, 32'h0000_7FFF);
    idle_cycle();
    idle_cycle();
    check("grant_count", 32'(n_gnt), 32'(exp_gnt));

    chk_on = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
